// File: rtl/nanov_spi_fetch_if.sv
// rtl/nanov_spi_fetch_if.sv - instruction stream and SPI flash pins of the fetch unit
interface nanov_spi_fetch_if #(
    parameter int ADDR_BITS = 24
);
    logic [31:0]          instr;
    logic [ADDR_BITS-1:0] instr_addr;
    logic                 instr_valid;
    logic                 instr_ready;
    logic                 spi_cs_n;
    logic                 spi_clk;
    logic                 spi_mosi;
    logic                 spi_miso;

    modport master (
        output instr, instr_addr, instr_valid, spi_cs_n, spi_clk, spi_mosi,
        input  instr_ready, spi_miso
    );

    modport slave (
        input  instr, instr_addr, instr_valid, spi_cs_n, spi_clk, spi_mosi,
        output instr_ready, spi_miso
    );
endinterface

// File: rtl/nanov_spi_fetch.sv
// rtl/nanov_spi_fetch.sv - streaming instruction fetch from SPI flash (mode 0, read opcode)
module nanov_spi_fetch #(
    parameter logic [7:0] READ_CMD  = 8'h03,
    parameter int         ADDR_BITS = 24
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic [ADDR_BITS-1:0] start_addr,
    output logic                 busy,
    nanov_spi_fetch_if.master    bus
);
    localparam int TXW = 8 + ADDR_BITS;
    localparam int CW  = $clog2(TXW > 32 ? TXW : 32);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, HOLD, DESEL} state_t;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [TXW-1:0]       tx_sr;
    logic [30:0]          rx_sr;
    logic [ADDR_BITS-1:0] fetch_addr;
    logic [ADDR_BITS-1:0] pend_addr;
    logic                 desel_cnt;

    logic [ADDR_BITS-1:0] start_word;
    logic                 launch;
    logic [ADDR_BITS-1:0] launch_addr;
    logic [31:0]          rx_full;

    assign start_word  = start_addr & ~ADDR_BITS'(3);
    assign launch      = (start && state == IDLE) || (state == DESEL && desel_cnt);
    assign launch_addr = (state == DESEL) ? pend_addr : start_word;
    assign rx_full     = {rx_sr, bus.spi_miso};
    assign busy        = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state           <= IDLE;
            cnt             <= '0;
            tx_sr           <= '0;
            rx_sr           <= '0;
            fetch_addr      <= '0;
            pend_addr       <= '0;
            desel_cnt       <= 1'b0;
            bus.spi_cs_n    <= 1'b1;
            bus.spi_clk     <= 1'b0;
            bus.spi_mosi    <= 1'b0;
            bus.instr       <= '0;
            bus.instr_addr  <= '0;
            bus.instr_valid <= 1'b0;
        end else if (start && state != IDLE) begin
            // Redirect beats any handshake; the partial word is simply never delivered.
            state           <= DESEL;
            pend_addr       <= start_word;
            desel_cnt       <= 1'b0;
            bus.spi_cs_n    <= 1'b1;
            bus.spi_clk     <= 1'b0;
            bus.spi_mosi    <= 1'b0;
            bus.instr_valid <= 1'b0;
        end else if (launch) begin
            state        <= CMD;
            fetch_addr   <= launch_addr;
            tx_sr        <= {READ_CMD[6:0], launch_addr, 1'b0};
            cnt          <= '0;
            bus.spi_cs_n <= 1'b0;
            bus.spi_clk  <= 1'b0;
            bus.spi_mosi <= READ_CMD[7];
        end else begin
            case (state)
                DESEL: desel_cnt <= 1'b1;
                CMD, ADDR: begin
                    if (!bus.spi_clk) begin
                        bus.spi_clk <= 1'b1;
                    end else begin
                        bus.spi_clk  <= 1'b0;
                        cnt          <= cnt + CW'(1);
                        bus.spi_mosi <= tx_sr[TXW-1];
                        tx_sr        <= tx_sr << 1;
                        if (cnt == CW'(7)) state <= ADDR;
                        if (cnt == CW'(TXW - 1)) begin
                            state        <= DATA;
                            cnt          <= '0;
                            bus.spi_mosi <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (!bus.spi_clk) begin
                        bus.spi_clk <= 1'b1;
                    end else begin
                        // miso is sampled on the edge that returns spi_clk to 0
                        bus.spi_clk <= 1'b0;
                        rx_sr       <= {rx_sr[29:0], bus.spi_miso};
                        cnt         <= cnt + CW'(1);
                        if (cnt == CW'(31)) begin
                            bus.instr       <= {rx_full[7:0], rx_full[15:8], rx_full[23:16], rx_full[31:24]};
                            bus.instr_addr  <= fetch_addr;
                            bus.instr_valid <= 1'b1;
                            state           <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (bus.instr_valid && bus.instr_ready) begin
                        bus.instr_valid <= 1'b0;
                        fetch_addr      <= fetch_addr + ADDR_BITS'(4);
                        cnt             <= '0;
                        state           <= DATA;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_nanov_spi_fetch.sv
// tb/tb_nanov_spi_fetch.sv - directed bench for nanov_spi_fetch with a behavioural SPI flash
module tb_nanov_spi_fetch;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [23:0] start_addr = 24'h0;
    logic        busy;

    nanov_spi_fetch_if #(.ADDR_BITS(24)) bus ();

    nanov_spi_fetch #(.READ_CMD(8'h03), .ADDR_BITS(24)) dut (
        .clk(clk), .rstn(rstn), .start(start), .start_addr(start_addr), .busy(busy), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // Flash contents: fixed first word at 0x100, elsewhere low byte XOR {a[11:8], a[23:20]}
    function automatic logic [7:0] mem_byte(input logic [23:0] a);
        case (a)
            24'h000100: return 8'h93;
            24'h000101: return 8'h00;
            24'h000102: return 8'h10;
            24'h000103: return 8'h00;
            default:    return a[7:0] ^ {a[11:8], a[23:20]};
        endcase
    endfunction

    int          fcnt = 0;
    int          k;
    logic [31:0] cap = 32'h0;
    logic [7:0]  fb;
    logic [7:0]  last_cmd = 8'h0;
    logic [23:0] last_addr = 24'h0;

    always @(posedge bus.spi_cs_n or posedge bus.spi_clk) begin
        if (bus.spi_cs_n !== 1'b0) begin
            fcnt = 0;
        end else begin
            if (fcnt < 32) cap = {cap[30:0], bus.spi_mosi};
            fcnt++;
            if (fcnt == 32) begin
                last_cmd  = cap[31:24];
                last_addr = cap[23:0];
            end
        end
    end

    always @(negedge bus.spi_clk) begin
        if (bus.spi_cs_n === 1'b0 && fcnt >= 32) begin
            k  = fcnt - 32;
            fb = mem_byte(last_addr + 24'(k / 8));
            bus.spi_miso = fb[3'(7 - (k % 8))];
        end
    end

    task automatic pulse_start(input logic [23:0] a);
        start_addr = a;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        start_addr = 24'hABCDEF;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (bus.instr_valid !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        bus.instr_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_total++; if (bus.spi_cs_n !== 1'b1) $display("FAIL reset_cs_n got %b want 1", bus.spi_cs_n); else n_pass++;
        n_total++; if (bus.spi_clk !== 1'b0) $display("FAIL reset_spi_clk got %b want 0", bus.spi_clk); else n_pass++;
        n_total++; if (bus.spi_mosi !== 1'b0) $display("FAIL reset_mosi got %b want 0", bus.spi_mosi); else n_pass++;
        n_total++; if (bus.instr_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", bus.instr_valid); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
        n_total++; if (bus.instr !== 32'h0) $display("FAIL reset_instr got %h want 0", bus.instr); else n_pass++;
        n_total++; if (bus.instr_addr !== 24'h0) $display("FAIL reset_addr got %h want 0", bus.instr_addr); else n_pass++;
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_first_word;
        int n;
        bus.instr_ready = 1'b1;
        pulse_start(24'h000100);
        n_total++; if (bus.spi_cs_n !== 1'b0) $display("FAIL first_cs_n got %b want 0", bus.spi_cs_n); else n_pass++;
        n_total++; if (bus.spi_mosi !== 1'b0) $display("FAIL first_mosi_msb got %b want 0", bus.spi_mosi); else n_pass++;
        n_total++; if (busy !== 1'b1) $display("FAIL first_busy got %b want 1", busy); else n_pass++;
        wait_valid(n);
        n_total++; if (n !== 128) $display("FAIL first_latency got %0d want 128", n); else n_pass++;
        n_total++; if (bus.instr !== 32'h00100093) $display("FAIL first_instr got %h want 00100093", bus.instr); else n_pass++;
        n_total++; if (bus.instr_addr !== 24'h000100) $display("FAIL first_addr got %h want 000100", bus.instr_addr); else n_pass++;
        n_total++; if (last_cmd !== 8'h03) $display("FAIL first_cmd got %h want 03", last_cmd); else n_pass++;
        n_total++; if (last_addr !== 24'h000100) $display("FAIL first_tx_addr got %h want 000100", last_addr); else n_pass++;
    endtask

    task automatic test_hold;
        int n;
        bus.instr_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_total++; if (bus.spi_clk !== 1'b0) $display("FAIL hold_spi_clk c%0d got %b want 0", i, bus.spi_clk); else n_pass++;
            n_total++; if (bus.spi_cs_n !== 1'b0) $display("FAIL hold_cs_n c%0d got %b want 0", i, bus.spi_cs_n); else n_pass++;
            n_total++; if (bus.instr !== 32'h00100093) $display("FAIL hold_instr c%0d got %h want 00100093", i, bus.instr); else n_pass++;
            n_total++; if (bus.instr_valid !== 1'b1) $display("FAIL hold_valid c%0d got %b want 1", i, bus.instr_valid); else n_pass++;
        end
        bus.instr_ready = 1'b1;
        @(negedge clk);
        n_total++; if (bus.instr_valid !== 1'b0) $display("FAIL hold_drop got %b want 0", bus.instr_valid); else n_pass++;
        wait_valid(n);
        n_total++; if (n !== 64) $display("FAIL next_latency got %0d want 64", n); else n_pass++;
        n_total++; if (bus.instr_addr !== 24'h000104) $display("FAIL next_addr got %h want 000104", bus.instr_addr); else n_pass++;
        n_total++; if (bus.instr !== 32'h17161514) $display("FAIL next_instr got %h want 17161514", bus.instr); else n_pass++;
    endtask

    task automatic test_restart_addr;
        int n;
        logic saw_valid;
        pulse_start(24'h000400);
        n_total++; if (bus.spi_cs_n !== 1'b1) $display("FAIL redir1_cs_n got %b want 1", bus.spi_cs_n); else n_pass++;
        saw_valid = 1'b0;
        repeat (42) begin
            @(negedge clk);
            if (bus.instr_valid === 1'b1) saw_valid = 1'b1;
        end
        n_total++; if (saw_valid !== 1'b0) $display("FAIL redir1_stale_valid got %b want 0", saw_valid); else n_pass++;
        n_total++; if (bus.spi_cs_n !== 1'b0) $display("FAIL redir1_in_addr_cs_n got %b want 0", bus.spi_cs_n); else n_pass++;
        pulse_start(24'h000200);
        n_total++; if (bus.spi_cs_n !== 1'b1) $display("FAIL desel0_cs_n got %b want 1", bus.spi_cs_n); else n_pass++;
        n_total++; if (bus.spi_clk !== 1'b0) $display("FAIL desel0_spi_clk got %b want 0", bus.spi_clk); else n_pass++;
        @(negedge clk);
        n_total++; if (bus.spi_cs_n !== 1'b1) $display("FAIL desel1_cs_n got %b want 1", bus.spi_cs_n); else n_pass++;
        @(negedge clk);
        n_total++; if (bus.spi_cs_n !== 1'b0) $display("FAIL desel2_cs_n got %b want 0", bus.spi_cs_n); else n_pass++;
        wait_valid(n);
        n_total++; if (n !== 128) $display("FAIL redir_latency got %0d want 128", n); else n_pass++;
        n_total++; if (bus.instr_addr !== 24'h000200) $display("FAIL redir_addr got %h want 000200", bus.instr_addr); else n_pass++;
        n_total++; if (bus.instr !== 32'h23222120) $display("FAIL redir_instr got %h want 23222120", bus.instr); else n_pass++;
        n_total++; if (last_cmd !== 8'h03) $display("FAIL redir_cmd got %h want 03", last_cmd); else n_pass++;
        n_total++; if (last_addr !== 24'h000200) $display("FAIL redir_tx_addr got %h want 000200", last_addr); else n_pass++;
        bus.instr_ready = 1'b0;
    endtask

    task automatic test_start_in_hold;
        int n;
        repeat (2) @(negedge clk);
        start_addr = 24'h000301;
        start = 1'b1;
        bus.instr_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        start_addr = 24'h123456;
        n_total++; if (bus.instr_valid !== 1'b0) $display("FAIL hold_start_valid got %b want 0", bus.instr_valid); else n_pass++;
        n_total++; if (bus.spi_cs_n !== 1'b1) $display("FAIL hold_start_cs_n got %b want 1", bus.spi_cs_n); else n_pass++;
        wait_valid(n);
        n_total++; if (n !== 130) $display("FAIL hold_start_latency got %0d want 130", n); else n_pass++;
        n_total++; if (bus.instr_addr !== 24'h000300) $display("FAIL hold_start_addr got %h want 000300", bus.instr_addr); else n_pass++;
        n_total++; if (bus.instr !== 32'h33323130) $display("FAIL hold_start_instr got %h want 33323130", bus.instr); else n_pass++;
    endtask

    task automatic test_wrap;
        int n;
        bus.instr_ready = 1'b1;
        pulse_start(24'hFFFFFC);
        wait_valid(n);
        n_total++; if (n !== 130) $display("FAIL wrap_latency got %0d want 130", n); else n_pass++;
        n_total++; if (bus.instr_addr !== 24'hFFFFFC) $display("FAIL wrap_addr0 got %h want fffffc", bus.instr_addr); else n_pass++;
        n_total++; if (bus.instr !== 32'h00010203) $display("FAIL wrap_instr0 got %h want 00010203", bus.instr); else n_pass++;
        @(negedge clk);
        n_total++; if (bus.instr_valid !== 1'b0) $display("FAIL wrap_drop got %b want 0", bus.instr_valid); else n_pass++;
        wait_valid(n);
        n_total++; if (n !== 64) $display("FAIL wrap_next_latency got %0d want 64", n); else n_pass++;
        n_total++; if (bus.instr_addr !== 24'h000000) $display("FAIL wrap_addr1 got %h want 000000", bus.instr_addr); else n_pass++;
        n_total++; if (bus.instr !== 32'h03020100) $display("FAIL wrap_instr1 got %h want 03020100", bus.instr); else n_pass++;
    endtask

    task automatic test_reset_mid;
        int n;
        pulse_start(24'h000100);
        repeat (100) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        n_total++; if (bus.spi_cs_n !== 1'b1) $display("FAIL rst_mid_cs_n got %b want 1", bus.spi_cs_n); else n_pass++;
        n_total++; if (bus.instr_valid !== 1'b0) $display("FAIL rst_mid_valid got %b want 0", bus.instr_valid); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL rst_mid_busy got %b want 0", busy); else n_pass++;
        n_total++; if (bus.spi_clk !== 1'b0) $display("FAIL rst_mid_spi_clk got %b want 0", bus.spi_clk); else n_pass++;
        rstn = 1'b1;
        @(negedge clk);
        pulse_start(24'h000100);
        wait_valid(n);
        n_total++; if (n !== 128) $display("FAIL rst_refetch_latency got %0d want 128", n); else n_pass++;
        n_total++; if (bus.instr !== 32'h00100093) $display("FAIL rst_refetch_instr got %h want 00100093", bus.instr); else n_pass++;
        n_total++; if (bus.instr_addr !== 24'h000100) $display("FAIL rst_refetch_addr got %h want 000100", bus.instr_addr); else n_pass++;
    endtask

    initial begin
        bus.spi_miso = 1'b0;
        bus.instr_ready = 1'b0;
        test_reset();
        test_first_word();
        test_hold();
        test_restart_addr();
        test_start_in_hold();
        test_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout passed=%0d total=%0d", n_pass, n_total);
        $fatal(1);
    end
endmodule

// File: doc/nanov_spi_fetch.md
NANOV_SPI_FETCH -- requirements
Module: nanov_spi_fetch

Interface
REQ-001 Parameter READ_CMD, default 8'h03, SPI flash read opcode, sent MSB first.
REQ-002 Parameter ADDR_BITS, default 24, width of the flash byte address.
REQ-003 clk  input  1  system clock; all logic is clocked on the posedge.
REQ-004 rstn  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  one-cycle request to begin fetching at start_addr; also used for branch or redirect.
REQ-006 start_addr  input  ADDR_BITS  byte address of the first instruction; bits [1:0] are ignored and treated as 0.
REQ-007 instr  output  32  fetched instruction word in little-endian order.
REQ-008 instr_addr  output  ADDR_BITS  byte address of the word on instr.
REQ-009 instr_valid  output  1  instr and instr_addr hold a word that has not yet been consumed.
REQ-010 instr_ready  input  1  consumer accepts the word; transfer occurs when instr_valid and instr_ready are both high at a posedge.
REQ-011 busy  output  1  high whenever the state is not IDLE.
REQ-012 spi_cs_n  output  1  flash chip select, active-low, registered.
REQ-013 spi_clk  output  1  SPI clock, mode 0, registered.
REQ-014 spi_mosi  output  1  data to flash, registered.
REQ-015 spi_miso  input  1  data from flash.

Function
REQ-016 The FSM SHALL have the states IDLE, CMD (8 bits), ADDR (ADDR_BITS bits), DATA (32 bits), HOLD and DESEL.
REQ-017 Each SPI bit SHALL take 2 clk cycles: a low phase with spi_clk=0 and mosi updated, then a high phase with spi_clk=1.
REQ-018 spi_miso SHALL be sampled at the posedge that ends the high phase, i.e. the edge on which spi_clk returns to 0.
REQ-019 On start in IDLE: the next cycle SHALL have spi_cs_n=0, state CMD and mosi=READ_CMD[7].
REQ-020 The block SHALL send the opcode MSB first, then the address MSB first with bits [1:0] forced to 0.
REQ-021 DATA SHALL receive 4 bytes, each MSB first; byte k (k=0..3) fills instr[8k+7:8k].
REQ-022 After the 32nd data bit is sampled, instr_valid SHALL rise on the next cycle.
REQ-023 That word SHALL appear 128 clk cycles after the start edge when ADDR_BITS=24.
REQ-024 The state SHALL become HOLD and spi_clk SHALL stay 0 with spi_cs_n still 0.
REQ-025 In HOLD, instr, instr_addr and instr_valid SHALL be stable until the handshake completes.
REQ-026 On handshake: instr_valid SHALL drop next cycle and the state SHALL return to DATA with instr_addr+4.
REQ-027 The next word SHALL stream without re-sending the command, so each subsequent word takes 64 clk cycles.
REQ-028 A handshake in the same cycle that instr_valid rises SHALL be legal.
REQ-029 The address SHALL wrap modulo 2^ADDR_BITS; 0xFFFFFC+4 gives 0x000000 with no other effect.
REQ-030 On start while busy, in any state including HOLD: instr_valid SHALL clear next cycle, any partial word SHALL be discarded, and spi_cs_n=1, spi_clk=0.
REQ-031 DESEL SHALL then hold spi_cs_n=1 for exactly 2 cycles before CMD begins with the new address.
REQ-032 A start during DESEL SHALL replace the pending address and restart the 2-cycle deselect count.
REQ-033 start coincident with a handshake SHALL take priority: the word counts as consumed and no further word is delivered from the old stream.
REQ-034 start_addr SHALL be captured only on the start cycle; later changes have no effect.
REQ-035 spi_mosi SHALL be 0 during DATA, HOLD, DESEL and IDLE.

Reset
REQ-036 While rstn=0 at a posedge, the block SHALL set: state IDLE, spi_cs_n=1, spi_clk=0, spi_mosi=0, instr_valid=0, busy=0, instr=0 and instr_addr=0.
REQ-037 Reset mid-transfer SHALL abort immediately with no deselect delay; the first start after reset SHALL behave as from IDLE.

Verification
REQ-038 Bench SHALL run start, start_addr=0x000100, with the flash model returning bytes 93,00,10,00 and instr_ready=1.
- Required: MOSI shows 0x03 then 0x000100.
- Required: instr=0x00100093 and instr_addr=0x000100, with valid at cycle 128.
REQ-039 Bench SHALL hold instr_ready=0 for 20 cycles after valid.
- Required: spi_clk is static 0, cs_n stays 0 and instr is stable.
- Required: after ready, the next word at 0x000104 is valid 64 cycles later.
REQ-040 Bench SHALL assert start with 0x000200 midway through ADDR of a fetch.
- Required: cs_n high for exactly 2 cycles, then 0x03 0x000200 is sent.
- Required: no instr_valid for the old address.
REQ-041 Bench SHALL assert start in HOLD together with instr_ready.
- Required: instr_valid drops next cycle.
- Required: the next delivered instr_addr equals the new address.
REQ-042 Bench SHALL run start_addr=0xFFFFFC streaming two words.
- Required: instr_addr sequence 0xFFFFFC then 0x000000.
REQ-043 Bench SHALL pulse rstn=0 during DATA.
- Required: next cycle cs_n=1, instr_valid=0, busy=0.
- Required: a fresh start yields a correct first word at 128 cycles.
